// File: rtl/acc_req_mux.sv
// rtl/acc_req_mux.sv - round-robin accelerator request mux with ID-extended response routing (optional ACC_REQ_MUX_CUT_EN)
module acc_req_mux #(
    parameter int unsigned NumReq       = 4,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned AccAddrWidth = 4,
    parameter int unsigned InIdWidth    = 5,
    parameter int unsigned ExtIdWidth   = InIdWidth + $clog2(NumReq)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NumReq*AccAddrWidth-1:0] slv_q_addr_i,
    input  logic [NumReq*32-1:0]           slv_q_data_op_i,
    input  logic [NumReq*DataWidth-1:0]    slv_q_data_arga_i,
    input  logic [NumReq*DataWidth-1:0]    slv_q_data_argb_i,
    input  logic [NumReq*DataWidth-1:0]    slv_q_data_argc_i,
    input  logic [NumReq*InIdWidth-1:0]    slv_q_id_i,
    input  logic [NumReq-1:0]              slv_q_valid_i,
    output logic [NumReq-1:0]              slv_q_ready_o,
    output logic [NumReq*DataWidth-1:0]    slv_p_data_o,
    output logic [NumReq*ExtIdWidth-1:0]   slv_p_id_o,
    output logic [NumReq-1:0]              slv_p_error_o,
    output logic [NumReq-1:0]              slv_p_valid_o,
    input  logic [NumReq-1:0]              slv_p_ready_i,
    output logic [AccAddrWidth-1:0]        mst_q_addr_o,
    output logic [31:0]                    mst_q_data_op_o,
    output logic [DataWidth-1:0]           mst_q_data_arga_o,
    output logic [DataWidth-1:0]           mst_q_data_argb_o,
    output logic [DataWidth-1:0]           mst_q_data_argc_o,
    output logic [ExtIdWidth-1:0]          mst_q_id_o,
    output logic                           mst_q_valid_o,
    input  logic                           mst_q_ready_i,
    input  logic [DataWidth-1:0]           mst_p_data_i,
    input  logic [ExtIdWidth-1:0]          mst_p_id_i,
    input  logic                           mst_p_error_i,
    input  logic                           mst_p_valid_i,
    output logic                           mst_p_ready_o,
    output logic                           drop_o
);

    localparam int unsigned IdxW = $clog2(NumReq);
    typedef logic [IdxW-1:0] idx_t;

    idx_t                   rr_ptr_q, rr_ptr_d;
    idx_t                   rr_idx;
    logic                   rr_found;
    logic [IdxW:0]          cand;
    idx_t                   g;
    idx_t                   g_next;
    logic                   arb_valid;
    logic                   arb_ready;
    logic                   arb_hs;
    logic [AccAddrWidth-1:0] arb_addr;
    logic [31:0]            arb_op;
    logic [DataWidth-1:0]   arb_arga, arb_argb, arb_argc;
    logic [InIdWidth-1:0]   arb_slv_id;
    logic [ExtIdWidth-1:0]  arb_id;

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = '0;
        for (int k = 0; k < NumReq; k++) begin
            cand = {1'b0, rr_ptr_q} + (IdxW+1)'(k);
            if (cand >= (IdxW+1)'(NumReq)) begin
                cand = cand - (IdxW+1)'(NumReq);
            end
            if (!rr_found && slv_q_valid_i[cand[IdxW-1:0]]) begin
                rr_found = 1'b1;
                rr_idx   = cand[IdxW-1:0];
            end
        end
    end

    assign arb_valid = |slv_q_valid_i;
    assign arb_hs    = arb_valid && arb_ready;
    assign g_next    = (g == idx_t'(NumReq-1)) ? '0 : g + 1'b1;

    // Payload mux from the granted requester; the ID gains the requester index on top.
    always_comb begin
        arb_addr   = '0;
        arb_op     = '0;
        arb_arga   = '0;
        arb_argb   = '0;
        arb_argc   = '0;
        arb_slv_id = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (g == idx_t'(i)) begin
                arb_addr   = slv_q_addr_i[i*AccAddrWidth +: AccAddrWidth];
                arb_op     = slv_q_data_op_i[i*32 +: 32];
                arb_arga   = slv_q_data_arga_i[i*DataWidth +: DataWidth];
                arb_argb   = slv_q_data_argb_i[i*DataWidth +: DataWidth];
                arb_argc   = slv_q_data_argc_i[i*DataWidth +: DataWidth];
                arb_slv_id = slv_q_id_i[i*InIdWidth +: InIdWidth];
            end
        end
        arb_id = {g, arb_slv_id};
    end

    // Only the granted requester sees ready, and only when its request is accepted.
    always_comb begin
        slv_q_ready_o = '0;
        for (int i = 0; i < NumReq; i++) begin
            slv_q_ready_o[i] = arb_hs && (g == idx_t'(i));
        end
    end

    // The round-robin pointer advances past the winner on each accepted request.
    always_comb begin
        rr_ptr_d = arb_hs ? g_next : rr_ptr_q;
    end

    // Round-robin pointer register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

`ifdef ACC_REQ_MUX_CUT_EN
    logic                    full_q, full_d;
    logic [AccAddrWidth-1:0] addr_q;
    logic [31:0]             op_q;
    logic [DataWidth-1:0]    arga_q, argb_q, argc_q;
    logic [ExtIdWidth-1:0]   id_q;

    // The spill slot alone keeps the master side stable, so no grant lock is needed.
    assign g         = rr_idx;
    assign arb_ready = !full_q || mst_q_ready_i;

    // Slot fills on every accepted request and empties when the master drains it.
    always_comb begin
        full_d = full_q;
        if (arb_hs) begin
            full_d = 1'b1;
        end else if (mst_q_ready_i) begin
            full_d = 1'b0;
        end
    end

    // Spill register: full flag plus captured payload.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q <= 1'b0;
            addr_q <= '0;
            op_q   <= '0;
            arga_q <= '0;
            argb_q <= '0;
            argc_q <= '0;
            id_q   <= '0;
        end else begin
            full_q <= full_d;
            if (arb_hs) begin
                addr_q <= arb_addr;
                op_q   <= arb_op;
                arga_q <= arb_arga;
                argb_q <= arb_argb;
                argc_q <= arb_argc;
                id_q   <= arb_id;
            end
        end
    end

    assign mst_q_valid_o     = full_q;
    assign mst_q_addr_o      = addr_q;
    assign mst_q_data_op_o   = op_q;
    assign mst_q_data_arga_o = arga_q;
    assign mst_q_data_argb_o = argb_q;
    assign mst_q_data_argc_o = argc_q;
    assign mst_q_id_o        = id_q;
`else
    logic lock_q, lock_d;
    idx_t grant_q, grant_d;

    // Once a request is presented but stalled, the grant is frozen until it is accepted.
    assign g         = lock_q ? grant_q : rr_idx;
    assign arb_ready = mst_q_ready_i;

    // Lock on a stalled request; release on its handshake.
    always_comb begin
        lock_d  = lock_q;
        grant_d = grant_q;
        if (arb_hs) begin
            lock_d = 1'b0;
        end else if (arb_valid) begin
            lock_d  = 1'b1;
            grant_d = g;
        end
    end

    // Grant lock registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q  <= 1'b0;
            grant_q <= '0;
        end else begin
            lock_q  <= lock_d;
            grant_q <= grant_d;
        end
    end

    assign mst_q_valid_o     = arb_valid;
    assign mst_q_addr_o      = arb_addr;
    assign mst_q_data_op_o   = arb_op;
    assign mst_q_data_arga_o = arb_arga;
    assign mst_q_data_argb_o = arb_argb;
    assign mst_q_data_argc_o = arb_argc;
    assign mst_q_id_o        = arb_id;
`endif

    // ---------------- response path ----------------
    idx_t sel;
    logic sel_ok;
    logic drop_q, drop_d;

    assign sel    = mst_p_id_i[ExtIdWidth-1:InIdWidth];
    assign sel_ok = ({1'b0, sel} < (IdxW+1)'(NumReq));

    // Route valid to the selected requester and take its ready; unknown indices are swallowed.
    always_comb begin
        slv_p_valid_o = '0;
        mst_p_ready_o = 1'b1;
        for (int i = 0; i < NumReq; i++) begin
            if (sel_ok && (sel == idx_t'(i))) begin
                slv_p_valid_o[i] = mst_p_valid_i;
                mst_p_ready_o    = slv_p_ready_i[i];
            end
        end
    end

    assign slv_p_data_o  = {NumReq{mst_p_data_i}};
    assign slv_p_id_o    = {NumReq{mst_p_id_i}};
    assign slv_p_error_o = {NumReq{mst_p_error_i}};

    // Drop flag is sticky until reset.
    always_comb begin
        drop_d = drop_q || (mst_p_valid_i && !sel_ok);
    end

    // Drop flag register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_q <= 1'b0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_o = drop_q;

endmodule

// File: tb/tb_acc_req_mux.sv
// tb/tb_acc_req_mux.sv - directed self-checking bench for acc_req_mux
module tb_acc_req_mux;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // 4-requester instance
    logic [15:0]  q_addr;
    logic [127:0] q_op, q_arga, q_argb, q_argc;
    logic [19:0]  q_id;
    logic [3:0]   q_valid, q_ready;
    logic [127:0] p_data_o;
    logic [27:0]  p_id_o;
    logic [3:0]   p_err_o, p_valid_o, p_ready_i;
    logic [3:0]   m_addr;
    logic [31:0]  m_op, m_arga, m_argb, m_argc;
    logic [6:0]   m_id;
    logic         m_valid, m_ready;
    logic [31:0]  mp_data;
    logic [6:0]   mp_id;
    logic         mp_err, mp_valid, mp_ready;
    logic         drop4;

    acc_req_mux dut4 (
        .clk_i(clk), .rst_ni(rst_n),
        .slv_q_addr_i(q_addr), .slv_q_data_op_i(q_op),
        .slv_q_data_arga_i(q_arga), .slv_q_data_argb_i(q_argb), .slv_q_data_argc_i(q_argc),
        .slv_q_id_i(q_id), .slv_q_valid_i(q_valid), .slv_q_ready_o(q_ready),
        .slv_p_data_o(p_data_o), .slv_p_id_o(p_id_o), .slv_p_error_o(p_err_o),
        .slv_p_valid_o(p_valid_o), .slv_p_ready_i(p_ready_i),
        .mst_q_addr_o(m_addr), .mst_q_data_op_o(m_op),
        .mst_q_data_arga_o(m_arga), .mst_q_data_argb_o(m_argb), .mst_q_data_argc_o(m_argc),
        .mst_q_id_o(m_id), .mst_q_valid_o(m_valid), .mst_q_ready_i(m_ready),
        .mst_p_data_i(mp_data), .mst_p_id_i(mp_id), .mst_p_error_i(mp_err),
        .mst_p_valid_i(mp_valid), .mst_p_ready_o(mp_ready), .drop_o(drop4)
    );

    // 3-requester instance for out-of-range response indices
    logic [11:0] q3_addr = '0;
    logic [95:0] q3_op = '0, q3_arga = '0, q3_argb = '0, q3_argc = '0;
    logic [14:0] q3_id = '0;
    logic [2:0]  q3_valid = '0, q3_ready;
    logic [95:0] p3_data_o;
    logic [20:0] p3_id_o;
    logic [2:0]  p3_err_o, p3_valid_o, p3_ready_i;
    logic [3:0]  m3_addr;
    logic [31:0] m3_op, m3_arga, m3_argb, m3_argc;
    logic [6:0]  m3_id;
    logic        m3_valid;
    logic        m3_ready = 1'b0;
    logic [6:0]  mp3_id;
    logic        mp3_valid, mp3_ready;
    logic        drop3;

    acc_req_mux #(.NumReq(3)) dut3 (
        .clk_i(clk), .rst_ni(rst_n),
        .slv_q_addr_i(q3_addr), .slv_q_data_op_i(q3_op),
        .slv_q_data_arga_i(q3_arga), .slv_q_data_argb_i(q3_argb), .slv_q_data_argc_i(q3_argc),
        .slv_q_id_i(q3_id), .slv_q_valid_i(q3_valid), .slv_q_ready_o(q3_ready),
        .slv_p_data_o(p3_data_o), .slv_p_id_o(p3_id_o), .slv_p_error_o(p3_err_o),
        .slv_p_valid_o(p3_valid_o), .slv_p_ready_i(p3_ready_i),
        .mst_q_addr_o(m3_addr), .mst_q_data_op_o(m3_op),
        .mst_q_data_arga_o(m3_arga), .mst_q_data_argb_o(m3_argb), .mst_q_data_argc_o(m3_argc),
        .mst_q_id_o(m3_id), .mst_q_valid_o(m3_valid), .mst_q_ready_i(m3_ready),
        .mst_p_data_i(mp_data), .mst_p_id_i(mp3_id), .mst_p_error_i(mp_err),
        .mst_p_valid_i(mp3_valid), .mst_p_ready_o(mp3_ready), .drop_o(drop3)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        q_valid = '0;
        m_ready = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
    endtask

    logic [6:0] eid;
    int g;

    initial begin
        q_valid = '0; m_ready = 1'b0;
        p_ready_i = '0; mp_data = '0; mp_id = '0; mp_err = 1'b0; mp_valid = 1'b0;
        p3_ready_i = '0; mp3_id = '0; mp3_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            q_addr[i*4 +: 4]   = 4'(i + 1);
            q_op[i*32 +: 32]   = 32'h1000_0000 + 32'(i);
            q_arga[i*32 +: 32] = 32'hA000_0000 + 32'(i);
            q_argb[i*32 +: 32] = 32'hB000_0000 + 32'(i);
            q_argc[i*32 +: 32] = 32'hC000_0000 + 32'(i);
            q_id[i*5 +: 5]     = 5'(i + 8);
        end

        // Reset state
        next_cycle();
        @(negedge clk);
        check("rst_mst_valid", 64'(m_valid), 64'd0);
        check("rst_slv_ready", 64'(q_ready), 64'd0);
        check("rst_p_valid", 64'(p_valid_o), 64'd0);
        check("rst_drop4", 64'(drop4), 64'd0);
        check("rst_drop3", 64'(drop3), 64'd0);
        next_cycle();
        rst_n = 1'b1;

        // All four valid, ready high: strict rotation from 0
        q_valid = 4'b1111;
        m_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            g = k % 4;
            eid = {2'(g), 5'(g + 8)};
            @(negedge clk);
            check($sformatf("rr_ready_%0d", k), 64'(q_ready), 64'(4'b0001 << g));
            check($sformatf("rr_id_%0d", k), 64'(m_id), 64'(eid));
            check($sformatf("rr_arga_%0d", k), 64'(m_arga), 64'(32'hA000_0000 + 32'(g)));
            next_cycle();
        end

        // Single requester 1 (pointer wrapped back to 0)
        q_id[5 +: 5]  = 5'h03;
        q_op[32 +: 32] = 32'h0000_0033;
        q_valid = 4'b0010;
        @(negedge clk);
        check("single_valid", 64'(m_valid), 64'd1);
        check("single_id", 64'(m_id), 64'h23);
        check("single_op", 64'(m_op), 64'h33);
        check("single_ready", 64'(q_ready), 64'b0010);
        check("single_addr", 64'(m_addr), 64'd2);
        next_cycle();
        // Pointer now 2: among 0,2,3 requester 2 wins
        q_valid = 4'b1101;
        @(negedge clk);
        check("ptr_after_single", 64'(q_ready), 64'b0100);
        next_cycle();

        // Backpressure with requesters 0 and 2 from a fresh pointer
        apply_reset();
        q_valid = 4'b0101;
        m_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("bp_ready_%0d", k), 64'(q_ready), 64'd0);
            check($sformatf("bp_valid_%0d", k), 64'(m_valid), 64'd1);
            check($sformatf("bp_op_%0d", k), 64'(m_op), 64'h1000_0000);
            next_cycle();
        end
        m_ready = 1'b1;
        @(negedge clk);
        check("bp_release0", 64'(q_ready), 64'b0001);
        next_cycle();
        q_valid = 4'b0100;
        @(negedge clk);
        check("bp_release2", 64'(q_ready), 64'b0100);
        check("bp_id2", 64'(m_id), 64'({2'd2, 5'd10}));
        next_cycle();

        // Lock: pointer is 3, requester 0 stalls, then 3 arrives and must not steal the grant
        q_valid = 4'b0001;
        m_ready = 1'b0;
        @(negedge clk);
        check("lock_first", 64'(m_id), 64'({2'd0, 5'd8}));
        next_cycle();
        q_valid = 4'b1001;
        @(negedge clk);
        check("lock_hold_id", 64'(m_id), 64'({2'd0, 5'd8}));
        check("lock_hold_ready", 64'(q_ready), 64'd0);
        next_cycle();
        m_ready = 1'b1;
        @(negedge clk);
        check("lock_release", 64'(q_ready), 64'b0001);
        next_cycle();
        q_valid = 4'b1000;
        @(negedge clk);
        check("lock_next", 64'(q_ready), 64'b1000);
        check("lock_next_id", 64'(m_id), 64'({2'd3, 5'd11}));
        next_cycle();
        q_valid = '0;
        m_ready = 1'b0;

        // Response routing
        mp_data = 32'hDEAD_BEEF;
        mp_id = 7'h45;
        mp_err = 1'b1;
        mp_valid = 1'b1;
        p_ready_i = 4'b0100;
        @(negedge clk);
        check("p_valid_2", 64'(p_valid_o), 64'b0100);
        check("p_ready_2", 64'(mp_ready), 64'd1);
        check("p_id_bcast", 64'(p_id_o[0 +: 7]), 64'h45);
        check("p_data_bcast", 64'(p_data_o[96 +: 32]), 64'hDEAD_BEEF);
        check("p_err_bcast", 64'(p_err_o), 64'b1111);
        next_cycle();
        p_ready_i = 4'b1011;
        @(negedge clk);
        check("p_stall_ready", 64'(mp_ready), 64'd0);
        check("p_stall_valid", 64'(p_valid_o), 64'b0100);
        next_cycle();
        mp_id = 7'h05;
        p_ready_i = 4'b0001;
        @(negedge clk);
        check("p_valid_0", 64'(p_valid_o), 64'b0001);
        check("p_ready_0", 64'(mp_ready), 64'd1);
        check("p_drop4", 64'(drop4), 64'd0);
        next_cycle();
        mp_valid = 1'b0;

        // Three requesters: in-range then out-of-range index
        mp3_id = 7'h40;
        mp3_valid = 1'b1;
        p3_ready_i = 3'b000;
        @(negedge clk);
        check("p3_valid_2", 64'(p3_valid_o), 64'b100);
        check("p3_ready_2", 64'(mp3_ready), 64'd0);
        next_cycle();
        mp3_id = 7'h60;
        @(negedge clk);
        check("p3_oor_ready", 64'(mp3_ready), 64'd1);
        check("p3_oor_valid", 64'(p3_valid_o), 64'd0);
        check("p3_drop_before", 64'(drop3), 64'd0);
        next_cycle();
        mp3_valid = 1'b0;
        @(negedge clk);
        check("p3_drop_set", 64'(drop3), 64'd1);
        next_cycle();
        @(negedge clk);
        check("p3_drop_held", 64'(drop3), 64'd1);
        next_cycle();

        // Asynchronous reset between clock edges
        rst_n = 1'b0;
        q_valid = '0;
        #2;
        check("arst_drop3", 64'(drop3), 64'd0);
        check("arst_mst_valid", 64'(m_valid), 64'd0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
